// File: rtl/sync_hs_tx_if.sv
// sync_hs_tx_if: local word handshake and toggle req/ack crossing signals for sync_hs_tx
interface sync_hs_tx_if #(parameter int DW = 32);
  logic          src_vld;
  logic          src_rdy;
  logic [DW-1:0] src_data;
  logic          xfer_req;
  logic [DW-1:0] xfer_data;
  logic          xfer_ack;
  logic          done;
  logic          proto_err;
  logic          timeout;
  modport master (
    input  src_vld, src_data, xfer_ack,
    output src_rdy, xfer_req, xfer_data, done, proto_err, timeout
  );
  modport slave (
    output src_vld, src_data, xfer_ack,
    input  src_rdy, xfer_req, xfer_data, done, proto_err, timeout
  );
endinterface

// File: rtl/sync_hs_tx.sv
// sync_hs_tx: source end of a two-phase req/ack CDC handshake; optional WAIT_ACK timeout under SYNC_HS_TX_TIMEOUT_EN
module sync_hs_tx #(
  parameter int DW          = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TO_CYCLES   = 1023,
  parameter int TOW         = 10
) (
  input logic          clk,
  input logic          rst,
  sync_hs_tx_if.master bus
);
  typedef enum logic {IDLE, WAIT_ACK} state_t;
  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s, ack_prev, accept, complete;
  logic                   req, done_q, perr;
  logic [DW-1:0]          data;
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || (2**TOW) <= TO_CYCLES) begin : g_bad_params
    $error("sync_hs_tx: illegal parameter combination");
  end
  assign ack_s    = ack_sync[SYNC_STAGES-1];
  assign accept   = bus.src_vld && state == IDLE;
  assign complete = state == WAIT_ACK && ack_s == req;
  always_comb begin
    state_nxt = accept ? WAIT_ACK : complete ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ack_sync <= '0;
      ack_prev <= 1'b0;
      req      <= 1'b0;
      data     <= '0;
      done_q   <= 1'b0;
      perr     <= 1'b0;
    end else begin
      state    <= state_nxt;
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.xfer_ack};
      ack_prev <= ack_s;
      done_q   <= complete;
      if (state == IDLE && ack_s != ack_prev) perr <= 1'b1;
      if (accept) begin
        data <= bus.src_data;
        req  <= ~req;
      end
    end
  end
  assign bus.src_rdy   = state == IDLE;
  assign bus.xfer_req  = req;
  assign bus.xfer_data = data;
  assign bus.done      = done_q;
  assign bus.proto_err = perr;
`ifdef SYNC_HS_TX_TIMEOUT_EN
  logic [TOW-1:0] cnt;
  logic           to_q;
  // counter saturates at the limit so the flag cannot be lost to a wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      to_q <= 1'b0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == WAIT_ACK) begin
      if (cnt != TOW'(TO_CYCLES)) cnt <= cnt + 1'b1;
      if (cnt >= TOW'(TO_CYCLES - 1)) to_q <= 1'b1;
    end
  end
  assign bus.timeout = to_q;
`else
  assign bus.timeout = 1'b0;
`endif
endmodule

// File: tb/tb_sync_hs_tx.sv
// tb_sync_hs_tx: directed self-checking bench for sync_hs_tx (SYNC_STAGES=2, TO_CYCLES=8)
module tb_sync_hs_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic exp_req = 1'b0;
`ifdef SYNC_HS_TX_TIMEOUT_EN
  logic exp_to = 1'b1;
`else
  logic exp_to = 1'b0;
`endif
  always #5 clk = ~clk;
  sync_hs_tx_if #(.DW(32)) bus ();
  sync_hs_tx #(.DW(32), .SYNC_STAGES(2), .TO_CYCLES(8), .TOW(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    bus.src_vld  = 1'b0;
    bus.src_data = '0;
    bus.xfer_ack = 1'b0;
    step(3);
    chk("rst_req", {31'd0, bus.xfer_req}, 0);
    chk("rst_data", bus.xfer_data, 0);
    chk("rst_rdy", {31'd0, bus.src_rdy}, 1);
    chk("rst_done", {31'd0, bus.done}, 0);
    chk("rst_perr", {31'd0, bus.proto_err}, 0);
    chk("rst_to", {31'd0, bus.timeout}, 0);
    rst = 1'b0;
    step(2);
    // single word, ack five cycles after req, done three cycles after ack
    bus.src_vld  = 1'b1;
    bus.src_data = 32'hDEADBEEF;
    step(1);
    bus.src_vld = 1'b0;
    exp_req = ~exp_req;
    chk("sw_req", {31'd0, bus.xfer_req}, {31'd0, exp_req});
    chk("sw_data", bus.xfer_data, 32'hDEADBEEF);
    chk("sw_rdy", {31'd0, bus.src_rdy}, 0);
    step(5);
    bus.xfer_ack = exp_req;
    step(2);
    chk("sw_done_early", {31'd0, bus.done}, 0);
    chk("sw_rdy_early", {31'd0, bus.src_rdy}, 0);
    step(1);
    chk("sw_done", {31'd0, bus.done}, 1);
    chk("sw_rdy_done", {31'd0, bus.src_rdy}, 1);
    step(1);
    chk("sw_done_pulse", {31'd0, bus.done}, 0);
    // back-to-back: each accept lands in the done cycle of the previous word
    bus.src_vld  = 1'b1;
    bus.src_data = 32'd1;
    for (int k = 1; k <= 4; k++) begin
      step(1);
      exp_req = ~exp_req;
      chk("b2b_req", {31'd0, bus.xfer_req}, {31'd0, exp_req});
      chk("b2b_data", bus.xfer_data, 32'(k));
      bus.src_data = 32'(k + 1);
      bus.xfer_ack = exp_req;
      step(2);
      chk("b2b_wait_done", {31'd0, bus.done}, 0);
      step(1);
      chk("b2b_done", {31'd0, bus.done}, 1);
      chk("b2b_rdy", {31'd0, bus.src_rdy}, 1);
      if (k == 4) bus.src_vld = 1'b0;
    end
    step(1);
    chk("b2b_no_dup_req", {31'd0, bus.xfer_req}, {31'd0, exp_req});
    chk("b2b_no_dup_data", bus.xfer_data, 32'd4);
    // hold under pressure
    bus.src_vld  = 1'b1;
    bus.src_data = 32'hA5A5A5A5;
    step(1);
    exp_req = ~exp_req;
    for (int i = 0; i < 4; i++) begin
      bus.src_data = 32'h1000 + 32'(i);
      step(1);
      chk("hold_rdy", {31'd0, bus.src_rdy}, 0);
      chk("hold_data", bus.xfer_data, 32'hA5A5A5A5);
      chk("hold_req", {31'd0, bus.xfer_req}, {31'd0, exp_req});
    end
    bus.xfer_ack = exp_req;
    step(3);
    chk("hold_done", {31'd0, bus.done}, 1);
    bus.src_vld = 1'b0;
    step(2);
    chk("hold_perr_clean", {31'd0, bus.proto_err}, 0);
    // spurious ack while idle
    bus.xfer_ack = ~bus.xfer_ack;
    step(2);
    chk("sp_perr_early", {31'd0, bus.proto_err}, 0);
    step(1);
    chk("sp_perr", {31'd0, bus.proto_err}, 1);
    chk("sp_rdy", {31'd0, bus.src_rdy}, 1);
    step(5);
    chk("sp_perr_sticky", {31'd0, bus.proto_err}, 1);
    // reset mid-flight
    bus.src_vld  = 1'b1;
    bus.src_data = 32'h55;
    step(1);
    bus.src_vld = 1'b0;
    exp_req = ~exp_req;
    chk("mf_req", {31'd0, bus.xfer_req}, 1);
    step(2);
    rst = 1'b1;
    bus.xfer_ack = 1'b0;
    #1;
    chk("mf_rst_req", {31'd0, bus.xfer_req}, 0);
    chk("mf_rst_data", bus.xfer_data, 0);
    chk("mf_rst_rdy", {31'd0, bus.src_rdy}, 1);
    chk("mf_rst_done", {31'd0, bus.done}, 0);
    step(2);
    rst = 1'b0;
    exp_req = 1'b0;
    step(4);
    chk("mf_perr", {31'd0, bus.proto_err}, 0);
    chk("mf_to", {31'd0, bus.timeout}, 0);
    // timeout: never ack, then ack late
    bus.src_vld  = 1'b1;
    bus.src_data = 32'h77;
    step(1);
    bus.src_vld = 1'b0;
    exp_req = ~exp_req;
    step(7);
    chk("to_early", {31'd0, bus.timeout}, 0);
    step(1);
    chk("to_set", {31'd0, bus.timeout}, {31'd0, exp_to});
    step(6);
    chk("to_wait_rdy", {31'd0, bus.src_rdy}, 0);
    bus.xfer_ack = exp_req;
    step(3);
    chk("to_late_done", {31'd0, bus.done}, 1);
    chk("to_sticky", {31'd0, bus.timeout}, {31'd0, exp_to});
    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
